// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - ALU control codes, ALUOp/funct encodings and decode helper
package alu_operand_stage_pkg;

  typedef enum logic [3:0] {
    CTRL_AND = 4'd0,
    CTRL_OR  = 4'd1,
    CTRL_ADD = 4'd2,
    CTRL_SUB = 4'd6,
    CTRL_SLT = 4'd7,
    CTRL_LUI = 4'd8,
    CTRL_NOR = 4'd12,
    CTRL_ILL = 4'd15
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_LUI   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  typedef struct packed {
    alu_ctrl_e ctrl;
    logic      illegal;
  } decode_t;

  function automatic decode_t decode_ctrl(input logic [1:0] alu_op, input logic [5:0] funct);
    decode_t d;
    d.illegal = 1'b0;
    d.ctrl    = CTRL_ADD;
    case (alu_op)
      ALUOP_ADD: d.ctrl = CTRL_ADD;
      ALUOP_SUB: d.ctrl = CTRL_SUB;
      ALUOP_LUI: d.ctrl = CTRL_LUI;
      default: begin
        case (funct)
          FUNCT_AND: d.ctrl = CTRL_AND;
          FUNCT_OR:  d.ctrl = CTRL_OR;
          FUNCT_ADD: d.ctrl = CTRL_ADD;
          FUNCT_SUB: d.ctrl = CTRL_SUB;
          FUNCT_SLT: d.ctrl = CTRL_SLT;
          FUNCT_NOR: d.ctrl = CTRL_NOR;
          default: begin
            d.ctrl    = CTRL_ILL;
            d.illegal = 1'b1;
          end
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// rtl/alu_operand_stage_reg_file.sv - 2-read 1-write register file, R0 hardwired to zero, write-through bypass
module alu_operand_stage_reg_file #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic                            wr_ok;

  assign wr_ok = wr_en && (wr_addr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  // Same-cycle write is visible to readers so the decode stage never sees stale data
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0) rd_data_a = (wr_ok && rd_addr_a == wr_addr) ? wr_data : mem_q[rd_addr_a];
    if (rd_addr_b != '0) rd_data_b = (wr_ok && rd_addr_b == wr_addr) ? wr_data : mem_q[rd_addr_b];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch, ALU control decode and valid/ready pipeline register feeding the ALU
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int OP_SIZE    = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic [1:0]            alu_op,
  input  logic [5:0]            funct,
  input  logic                  use_imm,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_SIZE-1:0]    ALU_ctrl,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] data_2,
  output logic [ADDR_WIDTH-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic                  out_illegal
);
  logic [DATA_WIDTH-1:0] rs_data, rt_data;
  decode_t               dec;
  logic                  load;

  logic                  valid_q, valid_d;
  logic [OP_SIZE-1:0]    ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rw_q, rw_d, ill_q, ill_d;

  alu_operand_stage_reg_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .rd_addr_a(rs_addr),
    .rd_data_a(rs_data),
    .rd_addr_b(rt_addr),
    .rd_data_b(rt_data),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data)
  );

  assign dec      = decode_ctrl(alu_op, funct);
  assign in_ready = !valid_q || out_ready;
  // Flushed instructions are still consumed upstream but never captured
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    ctrl_d  = ctrl_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ill_d   = ill_q;
    valid_d = out_ready ? 1'b0 : valid_q;
    if (load) begin
      ctrl_d  = OP_SIZE'(dec.ctrl);
      d1_d    = rs_data;
      d2_d    = use_imm ? imm : rt_data;
      rd_d    = rd_addr;
      rw_d    = reg_write && !dec.illegal;
      ill_d   = dec.illegal;
      valid_d = 1'b1;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid     = valid_q;
  assign ALU_ctrl      = ctrl_q;
  assign data_1        = d1_q;
  assign data_2        = d2_q;
  assign out_rd_addr   = rd_q;
  assign out_reg_write = rw_q;
  assign out_illegal   = ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, reg_write, use_imm, flush, wb_en;
  logic       out_valid, out_ready, out_reg_write, out_illegal;
  logic [2:0] rs_addr, rt_addr, rd_addr, wb_addr, out_rd_addr;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [3:0] imm, wb_data, ALU_ctrl, data_1, data_2;

  int vectors = 0;
  int miscompares = 0;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .reg_write(reg_write),
    .alu_op(alu_op), .funct(funct), .use_imm(use_imm), .imm(imm), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_ctrl(ALU_ctrl),
    .data_1(data_1), .data_2(data_2), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                         input logic [3:0] d1, input logic [3:0] d2,
                         input logic [2:0] rd, input logic rw, input logic il);
    chk({tag, ".out_valid"},     32'(out_valid),     32'(v));
    chk({tag, ".ALU_ctrl"},      32'(ALU_ctrl),      32'(c));
    chk({tag, ".data_1"},        32'(data_1),        32'(d1));
    chk({tag, ".data_2"},        32'(data_2),        32'(d2));
    chk({tag, ".out_rd_addr"},   32'(out_rd_addr),   32'(rd));
    chk({tag, ".out_reg_write"}, 32'(out_reg_write), 32'(rw));
    chk({tag, ".out_illegal"},   32'(out_illegal),   32'(il));
  endtask

  initial begin
    reset = 1; in_valid = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0; reg_write = 0;
    alu_op = 0; funct = 0; use_imm = 0; imm = 0; flush = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    tick(); tick();
    reset = 0;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.in_ready", 32'(in_ready), 1);

    // 1: R3=5, R4=3, R-type SUB
    wb_en = 1; wb_addr = 3; wb_data = 4'h5; tick();
    wb_addr = 4; wb_data = 4'h3; tick();
    wb_en = 0;
    in_valid = 1; alu_op = 2'b10; funct = 6'h22; rs_addr = 3; rt_addr = 4; rd_addr = 5; reg_write = 1;
    tick();
    chk_out("sub", 1, 6, 5, 3, 5, 1, 0);

    // 2: bypass of R2 write, then R0 write ignored (back-to-back loads)
    wb_en = 1; wb_addr = 2; wb_data = 4'hA;
    alu_op = 2'b00; rs_addr = 2; rt_addr = 3; rd_addr = 1;
    tick();
    chk_out("bypass", 1, 2, 4'hA, 5, 1, 1, 0);
    wb_addr = 0; wb_data = 4'hF; alu_op = 2'b01; rs_addr = 0; rt_addr = 2; rd_addr = 2;
    tick();
    chk_out("r0", 1, 6, 0, 4'hA, 2, 1, 0);
    wb_en = 0;

    // 3: stall three cycles with a pending instruction; a write to R4 lands meanwhile
    out_ready = 0; alu_op = 2'b10; funct = 6'h20; rs_addr = 4; rt_addr = 3; rd_addr = 7;
    #1;
    chk("stall.in_ready", 32'(in_ready), 0);
    wb_en = 1; wb_addr = 4; wb_data = 4'h7;
    tick();
    wb_en = 0;
    for (int i = 0; i < 2; i++) tick();
    chk_out("stall", 1, 6, 0, 4'hA, 2, 1, 0);
    chk("stall.in_ready2", 32'(in_ready), 0);
    out_ready = 1;
    #1;
    chk("release.in_ready", 32'(in_ready), 1);
    tick();
    chk_out("release", 1, 2, 7, 5, 7, 1, 0);

    // 4: illegal funct
    funct = 6'h3F; rd_addr = 6; reg_write = 1;
    tick();
    chk_out("illegal", 1, 15, 7, 5, 6, 0, 1);

    // 5: flush while holding, then flush of an accepted instruction
    out_ready = 0; flush = 1; alu_op = 2'b00; rs_addr = 3;
    tick();
    chk_out("flush_held", 0, 15, 7, 5, 6, 0, 1);
    out_ready = 1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 1);
    tick();
    chk_out("flush_acc", 0, 15, 7, 5, 6, 0, 1);
    flush = 0;

    // 6: LUI with immediate, stall, then reset during the stall
    out_ready = 0; alu_op = 2'b11; use_imm = 1; imm = 4'h9; rs_addr = 3; rd_addr = 3; reg_write = 1;
    tick();
    chk_out("lui", 1, 8, 5, 9, 3, 1, 0);
    in_valid = 0;
    tick();
    chk_out("lui_hold", 1, 8, 5, 9, 3, 1, 0);
    reset = 1;
    tick();
    reset = 0;
    chk_out("reset_stall", 0, 0, 0, 0, 0, 0, 0);

    // register file cleared by reset
    out_ready = 1; in_valid = 1; use_imm = 0; alu_op = 2'b00; rs_addr = 3; rt_addr = 4; rd_addr = 1;
    tick();
    in_valid = 0;
    chk_out("rf_cleared", 1, 2, 0, 0, 1, 1, 0);
    tick();
    chk("drain.out_valid", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
